// File: rtl/pc_return_stack.sv
// Program counter with an integrated hardware return-address stack.
// Ports: clock/reset; in (target/offset); inc/load/branch/call/ret/clear_err
// requests; out (PC), top (TOS or 0), sp, full, empty, sticky overflow/underflow.
module pc_return_stack #(
  parameter int                        DATA_SIZE    = 16,
  parameter int                        STACK_DEPTH  = 8,
  parameter logic [DATA_SIZE-1:0]      RESET_VECTOR = '0,
  parameter int                        SP_W         = $clog2(STACK_DEPTH+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in,
  input  logic                 inc,
  input  logic                 load,
  input  logic                 branch,
  input  logic                 call,
  input  logic                 ret,
  input  logic                 clear_err,
  output logic [DATA_SIZE-1:0] out,
  output logic [DATA_SIZE-1:0] top,
  output logic [SP_W-1:0]      sp,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DATA_SIZE-1:0] stack [STACK_DEPTH];
  logic [DATA_SIZE-1:0] pc_inc;
  logic [SP_W-1:0]      sp_dec;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;

  assign pc_inc = out + DATA_SIZE'(1);
  assign sp_dec = sp - SP_W'(1);
  // Index widths are trimmed; sp only reaches STACK_DEPTH when full,
  // and writes are blocked in that case.
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = sp_dec[IDX_W-1:0];

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign top   = empty ? '0 : stack[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out       <= RESET_VECTOR;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      // Placed before the operations so a same-cycle error set wins.
      if (clear_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (call) begin
        if (full) begin
          out      <= pc_inc;
          overflow <= 1'b1;
        end else begin
          stack[wr_idx] <= pc_inc;
          sp            <= sp + SP_W'(1);
          out           <= in;
        end
      end else if (ret) begin
        if (empty) begin
          out       <= pc_inc;
          underflow <= 1'b1;
        end else begin
          out <= stack[rd_idx];
          sp  <= sp_dec;
        end
      end else if (load) begin
        out <= in;
      end else if (branch) begin
        out <= out + in;
      end else if (inc) begin
        out <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed self-checking bench for pc_return_stack.
// Drives a linear sequence of operations and checks PC/stack/flag state.
module tb_pc_return_stack;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        inc, load, branch, call, ret, clear_err;
  logic [15:0] out, top;
  logic [2:0]  sp;
  logic        full, empty, overflow, underflow;

  int tests  = 0;
  int failed = 0;

  pc_return_stack #(
    .DATA_SIZE   (16),
    .STACK_DEPTH (4),
    .RESET_VECTOR(16'h0100)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .inc      (inc),
    .load     (load),
    .branch   (branch),
    .call     (call),
    .ret      (ret),
    .clear_err(clear_err),
    .out      (out),
    .top      (top),
    .sp       (sp),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // c r l b i ce, data; applied for one rising edge, sampled 1 after it
  task automatic op(input logic c, input logic r, input logic l,
                    input logic b, input logic i, input logic ce,
                    input logic [15:0] d);
    call = c; ret = r; load = l; branch = b; inc = i; clear_err = ce;
    in = d;
    @(posedge clock);
    #1;
    call = 0; ret = 0; load = 0; branch = 0; inc = 0; clear_err = 0;
    in = '0;
  endtask

  initial begin
    reset = 1; in = '0;
    inc = 0; load = 0; branch = 0; call = 0; ret = 0; clear_err = 0;
    #12;
    chk("rst_out", out, 16'h0100);
    chk("rst_sp", sp, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_top", top, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    reset = 0;

    op(0,0,0,0,1,0,16'h0); chk("inc1", out, 16'h0101);
    op(0,0,0,0,1,0,16'h0); chk("inc2", out, 16'h0102);
    op(0,0,0,0,1,0,16'h0); chk("inc3", out, 16'h0103);
    chk("inc_sp", sp, 0);
    chk("inc_empty", empty, 1);
    op(0,0,1,0,0,0,16'hFFFF); chk("load_ffff", out, 16'hFFFF);
    op(0,0,0,0,1,0,16'h0); chk("inc_wrap", out, 16'h0000);

    // nesting
    op(0,0,1,0,0,0,16'h0010);
    op(1,0,0,0,0,0,16'h0200); chk("call1_out", out, 16'h0200);
    chk("call1_top", top, 16'h0011);
    op(1,0,0,0,0,0,16'h0300); chk("call2_out", out, 16'h0300);
    chk("call2_sp", sp, 2);
    chk("call2_top", top, 16'h0201);
    op(0,1,0,0,0,0,16'h0); chk("ret1_out", out, 16'h0201);
    chk("ret1_sp", sp, 1);
    op(0,1,0,0,0,0,16'h0); chk("ret2_out", out, 16'h0011);
    chk("ret2_sp", sp, 0);
    chk("ret2_empty", empty, 1);

    // overflow / underflow
    op(0,0,1,0,0,0,16'h1000);
    op(1,0,0,0,0,0,16'h2000);
    op(1,0,0,0,0,0,16'h3000);
    op(1,0,0,0,0,0,16'h4000);
    chk("c3_full", full, 0);
    op(1,0,0,0,0,0,16'h5000);
    chk("c4_full", full, 1);
    chk("c4_sp", sp, 4);
    chk("c4_top", top, 16'h4001);
    op(1,0,0,0,0,0,16'h6000);
    chk("c5_out", out, 16'h5001);
    chk("c5_ovf", overflow, 1);
    chk("c5_sp", sp, 4);
    chk("c5_top", top, 16'h4001);
    op(0,1,0,0,0,0,16'h0); chk("pop1", out, 16'h4001);
    op(0,1,0,0,0,0,16'h0); chk("pop2", out, 16'h3001);
    op(0,1,0,0,0,0,16'h0); chk("pop3", out, 16'h2001);
    chk("pop3_udf", underflow, 0);
    op(0,1,0,0,0,0,16'h0); chk("pop4", out, 16'h1001);
    chk("pop4_empty", empty, 1);
    op(0,1,0,0,0,0,16'h0); chk("pop5_out", out, 16'h1002);
    chk("pop5_udf", underflow, 1);
    chk("pop5_sp", sp, 0);
    chk("pop5_ovf", overflow, 1);
    op(0,0,0,0,0,1,16'h0);
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);
    chk("clr_hold", out, 16'h1002);

    // relative branch
    op(0,0,1,0,0,0,16'h0050);
    op(0,0,0,1,0,0,16'hFFF0); chk("br_neg", out, 16'h0040);
    op(0,0,0,1,0,0,16'h0020); chk("br_pos", out, 16'h0060);
    op(0,0,1,0,0,0,16'hFFF8);
    op(0,0,0,1,0,0,16'h0010); chk("br_wrap", out, 16'h0008);

    // priority
    op(1,1,1,0,1,0,16'h0400); chk("pri_call_out", out, 16'h0400);
    chk("pri_call_sp", sp, 1);
    chk("pri_call_top", top, 16'h0009);
    op(0,0,1,1,1,0,16'h0123); chk("pri_load", out, 16'h0123);
    op(0,1,0,0,0,0,16'h0); chk("pri_ret", out, 16'h0009);
    op(0,1,0,0,0,1,16'h0); chk("ce_udf_set", underflow, 1);
    chk("ce_udf_out", out, 16'h000A);
    op(0,0,0,0,0,0,16'h0); chk("hold", out, 16'h000A);

    // return address wraps
    op(0,0,1,0,0,0,16'hFFFF);
    op(1,0,0,0,0,0,16'h0777); chk("callwrap_top", top, 16'h0000);
    op(0,1,0,0,0,0,16'h0); chk("retwrap_out", out, 16'h0000);

    // async reset mid-sequence
    op(1,0,0,0,0,0,16'h0A00);
    op(1,0,0,0,0,0,16'h0B00);
    op(1,0,0,0,0,0,16'h0C00);
    chk("pre_rst_sp", sp, 3);
    chk("pre_rst_udf", underflow, 1);
    #1 reset = 1;
    #1;
    chk("arst_out", out, 16'h0100);
    chk("arst_sp", sp, 0);
    chk("arst_top", top, 0);
    chk("arst_udf", underflow, 0);
    chk("arst_ovf", overflow, 0);
    #1 reset = 0;
    op(0,1,0,0,0,0,16'h0);
    chk("post_rst_udf", underflow, 1);
    chk("post_rst_out", out, 16'h0101);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
